// File: rtl/dcache_ctrl.sv
// Blocking write-back data-cache controller: hit/miss handling, dirty-line writeback,
// line allocate/refill sequencing and a wrapping miss counter.
module dcache_ctrl #(
  parameter int IDX   = 12,
  parameter int TAG   = 9,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [IDX-1:0]     cpu_index,
  input  logic [TAG-1:0]     cpu_tag,
  input  logic               tag_hit,
  input  logic               tag_dirty,
  input  logic [TAG-1:0]     tag_old,
  input  logic               mem_ready,
  output logic               cpu_stall,
  output logic               replace_tag,
  output logic               valid_out,
  output logic               dirty_out,
  output logic               data_we,
  output logic               fill_we,
  output logic               mem_rd_req,
  output logic               mem_wr_req,
  output logic [TAG+IDX-1:0] mem_addr,
  output logic [CNT_W-1:0]   miss_count
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     miss_count_q, miss_count_d;
  logic [TAG+IDX-1:0]   mem_addr_q, mem_addr_d;
  logic [TAG-1:0]       req_tag_q, req_tag_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Transfer address is captured at the miss so it stays constant even if the CPU drops its request.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    req_tag_q  <= req_tag_d;
  end

  always_comb begin
    state_d      = state_q;
    miss_count_d = miss_count_q;
    mem_addr_d   = mem_addr_q;
    req_tag_d    = req_tag_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && !tag_hit) begin
          miss_count_d = miss_count_q + CNT_W'(1);
          req_tag_d    = cpu_tag;
          if (tag_dirty) begin
            state_d    = WRITEBACK;
            mem_addr_d = {tag_old, cpu_index};
          end else begin
            state_d    = ALLOCATE;
            mem_addr_d = {cpu_tag, cpu_index};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          state_d    = ALLOCATE;
          mem_addr_d = {req_tag_q, mem_addr_q[IDX-1:0]};
        end
      end
      ALLOCATE: begin
        if (mem_ready) state_d = REFILL;
      end
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall   = 1'b0;
    replace_tag = 1'b0;
    valid_out   = 1'b0;
    dirty_out   = 1'b0;
    data_we     = 1'b0;
    fill_we     = 1'b0;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (!tag_hit) begin
            cpu_stall = 1'b1;
          end else if (cpu_we) begin
            data_we     = 1'b1;
            replace_tag = 1'b1;
            valid_out   = 1'b1;
            dirty_out   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall  = 1'b1;
        mem_wr_req = 1'b1;
        mem_addr   = mem_addr_q;
      end
      ALLOCATE: begin
        cpu_stall  = 1'b1;
        mem_rd_req = 1'b1;
        mem_addr   = mem_addr_q;
        if (mem_ready) begin
          fill_we     = 1'b1;
          replace_tag = 1'b1;
          valid_out   = 1'b1;
        end
      end
      REFILL:  cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: drives CPU, a behavioural tag array and memory, and scoreboards
// each completed request against a cache model built from the hit/miss/latency rules.
module tb_dcache_ctrl;
  localparam int IDX = 12, TAG = 9, CNT_W = 4, AW = IDX + TAG;

  logic clk = 1'b0;
  logic rst, cpu_req, cpu_we, tag_hit, tag_dirty, mem_ready;
  logic [IDX-1:0] cpu_index;
  logic [TAG-1:0] cpu_tag, tag_old;
  logic cpu_stall, replace_tag, valid_out, dirty_out, data_we, fill_we, mem_rd_req, mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [CNT_W-1:0] miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(.IDX(IDX), .TAG(TAG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_index(cpu_index),
    .cpu_tag(cpu_tag), .tag_hit(tag_hit), .tag_dirty(tag_dirty), .tag_old(tag_old),
    .mem_ready(mem_ready), .cpu_stall(cpu_stall), .replace_tag(replace_tag),
    .valid_out(valid_out), .dirty_out(dirty_out), .data_we(data_we), .fill_we(fill_we),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .miss_count(miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Environment tag array, written by the controller's strobes on negedge
  logic           env_valid [4096];
  logic [TAG-1:0] env_tag   [4096];
  logic           env_dirty [4096];

  assign tag_hit   = env_valid[cpu_index] && (env_tag[cpu_index] == cpu_tag);
  assign tag_dirty = env_dirty[cpu_index];
  assign tag_old   = env_tag[cpu_index];

  always @(negedge clk) begin
    if (replace_tag) begin
      env_valid[cpu_index] = valid_out;
      env_tag[cpu_index]   = cpu_tag;
      env_dirty[cpu_index] = dirty_out;
    end
  end

  // Memory: ready arrives in the N-th cycle of a request; random stray pulses otherwise
  int cur_nwr = 1, cur_nrd = 1, wr_c = 0, rd_c = 0;
  initial mem_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    if (mem_wr_req) wr_c++; else wr_c = 0;
    if (mem_rd_req) rd_c++; else rd_c = 0;
    if (mem_wr_req)      mem_ready = (wr_c == cur_nwr);
    else if (mem_rd_req) mem_ready = (rd_c == cur_nrd);
    else                 mem_ready = ($urandom_range(0, 3) == 0);
  end

  // Reference cache model
  typedef struct {
    logic          we;
    logic          miss;
    logic          dirty;
    logic [AW-1:0] wb_addr;
    logic [AW-1:0] rd_addr;
    int            nwr;
    int            nrd;
    int            stall;
    logic [CNT_W-1:0] mcount;
  } exp_t;

  exp_t exp_q[$];
  logic           ref_valid [4096];
  logic [TAG-1:0] ref_tag   [4096];
  logic           ref_dirty [4096];
  logic [CNT_W-1:0] ref_mcount = '0;

  task automatic push_expect(input logic [IDX-1:0] idx, input logic [TAG-1:0] tag,
                             input logic we, input int nwr, input int nrd);
    exp_t e;
    e.we      = we;
    e.miss    = !(ref_valid[idx] && ref_tag[idx] == tag);
    e.dirty   = e.miss && ref_valid[idx] && ref_dirty[idx];
    e.wb_addr = {ref_tag[idx], idx};
    e.rd_addr = {tag, idx};
    e.nwr     = nwr;
    e.nrd     = nrd;
    e.stall   = e.miss ? ((e.dirty ? nwr : 0) + nrd + 2) : 0;
    if (e.miss) begin
      ref_mcount     = ref_mcount + 1'b1;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
      ref_dirty[idx] = we;
    end else if (we) begin
      ref_dirty[idx] = 1'b1;
    end
    e.mcount = ref_mcount;
    exp_q.push_back(e);
  endtask

  // Monitor: accumulates what the DUT does during a request, compares on completion
  logic mon_en = 1'b0;
  logic done_flag = 1'b0;
  int stall_cnt = 0, wr_cnt = 0, rd_cnt = 0, fill_cnt = 0;
  logic [AW-1:0] wr_addr0 = '0, rd_addr0 = '0, last_wb_addr = '0;
  logic [3:0] flags = '0;
  exp_t mon_e;

  always @(posedge clk) begin
    #8;
    if (mon_en) begin
      if (cpu_req) begin
        if (mem_rd_req && mem_wr_req) flags[0] = 1'b1;
        if (cpu_stall) stall_cnt++;
        if (mem_wr_req) begin
          wr_cnt++;
          if (wr_cnt == 1) wr_addr0 = mem_addr;
          else if (mem_addr != wr_addr0) flags[1] = 1'b1;
        end
        if (mem_rd_req) begin
          rd_cnt++;
          if (rd_cnt == 1) rd_addr0 = mem_addr;
          else if (mem_addr != rd_addr0) flags[1] = 1'b1;
        end
        if (fill_we) begin
          fill_cnt++;
          if (!(replace_tag && valid_out && !dirty_out)) flags[2] = 1'b1;
        end else if (cpu_stall && (replace_tag || data_we)) begin
          flags[3] = 1'b1;
        end
        if (!cpu_stall) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("stall_cycles", 64'(stall_cnt), 64'(mon_e.stall));
            check("wr_cycles", 64'(wr_cnt), 64'(mon_e.dirty ? mon_e.nwr : 0));
            if (mon_e.dirty) check("wb_addr", 64'(wr_addr0), 64'(mon_e.wb_addr));
            check("rd_cycles", 64'(rd_cnt), 64'(mon_e.miss ? mon_e.nrd : 0));
            if (mon_e.miss) check("rd_addr", 64'(rd_addr0), 64'(mon_e.rd_addr));
            check("fill_count", 64'(fill_cnt), 64'(mon_e.miss ? 1 : 0));
            check("protocol_flags", 64'(flags), 64'd0);
            check("final_strobes",
                  64'({data_we, replace_tag, valid_out, dirty_out, fill_we, mem_rd_req, mem_wr_req}),
                  64'(mon_e.we ? 7'b1111000 : 7'b0));
            check("miss_count", 64'(miss_count), 64'(mon_e.mcount));
            last_wb_addr = wr_addr0;
          end
          stall_cnt = 0; wr_cnt = 0; rd_cnt = 0; fill_cnt = 0; flags = '0;
          done_flag = 1'b1;
        end
      end else begin
        check("idle_outputs",
              64'({cpu_stall, replace_tag, valid_out, dirty_out, data_we, fill_we,
                   mem_rd_req, mem_wr_req, mem_addr}), 64'd0);
      end
    end
  end

  task automatic do_txn(input logic [IDX-1:0] idx, input logic [TAG-1:0] tag,
                        input logic we, input int nwr, input int nrd);
    cur_nwr = nwr;
    cur_nrd = nrd;
    push_expect(idx, tag, we, nwr, nrd);
    cpu_req = 1'b1; cpu_we = we; cpu_index = idx; cpu_tag = tag;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_flag) break;
    end
    if (!done_flag) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: actual=stalled required=complete idx=%0h tag=%0h", idx, tag);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else begin
      done_flag = 1'b0;
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [TAG-1:0] tags [4];

  initial begin
    tags = '{9'h1AB, 9'h055, 9'h0F0, 9'h12C};
    for (int i = 0; i < 4096; i++) begin
      env_valid[i] = 1'b0; env_tag[i] = '0; env_dirty[i] = 1'b0;
      ref_valid[i] = 1'b0; ref_tag[i] = '0; ref_dirty[i] = 1'b0;
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_index = '0; cpu_tag = '0;
    #2;
    check("reset_outputs",
          64'({cpu_stall, replace_tag, valid_out, dirty_out, data_we, fill_we,
               mem_rd_req, mem_wr_req, mem_addr, miss_count}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_outputs",
          64'({cpu_stall, replace_tag, valid_out, dirty_out, data_we, fill_we,
               mem_rd_req, mem_wr_req, mem_addr, miss_count}), 64'd0);
    mon_en = 1'b1;

    // Clean read miss, then read hit and store hit on the filled line
    do_txn(12'h020, 9'h003, 1'b0, 1, 3);
    do_txn(12'h020, 9'h003, 1'b0, 1, 1);
    do_txn(12'h020, 9'h003, 1'b1, 1, 1);

    // Dirty store miss evicting line 1AB at index 010
    do_txn(12'h010, 9'h1AB, 1'b1, 1, 2);
    do_txn(12'h010, 9'h055, 1'b1, 2, 3);
    check("dirty_wb_addr", 64'(last_wb_addr), 64'h1AB010);

    for (int n = 0; n < 80; n++) begin
      do_txn(12'h010 + IDX'($urandom_range(0, 3)), tags[$urandom_range(0, 3)],
             1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // CPU drops its request mid-allocate: transfer completes, no recount on retry
    mon_en = 1'b0;
    ref_mcount = ref_mcount + 1'b1;
    ref_valid[12'h200] = 1'b1; ref_tag[12'h200] = 9'h007; ref_dirty[12'h200] = 1'b0;
    cur_nrd = 3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_index = 12'h200; cpu_tag = 9'h007;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #3;
      if (!mem_rd_req) break;
    end
    @(posedge clk); #1;
    check("drop_req_miss_count", 64'(miss_count), 64'(ref_mcount));
    check("drop_req_idle_stall", 64'(cpu_stall), 64'd0);
    mon_en = 1'b1;
    do_txn(12'h200, 9'h007, 1'b0, 1, 1);

    // Asynchronous reset while allocating
    mon_en = 1'b0;
    cur_nrd = 4;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_index = 12'h100; cpu_tag = 9'h005;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #3;
      if (mem_rd_req) break;
    end
    check("alloc_reached", 64'(mem_rd_req), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_abandon", 64'({mem_rd_req, mem_wr_req, mem_addr, miss_count}), 64'd0);
    cpu_req = 1'b0;
    #1;
    check("rst_idle_outputs",
          64'({cpu_stall, replace_tag, valid_out, dirty_out, data_we, fill_we}), 64'd0);
    ref_mcount = '0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Sixteen consecutive misses wrap the 4-bit counter
    for (int i = 0; i < 16; i++)
      do_txn(12'h300, (i % 2 == 1) ? 9'h002 : 9'h001, 1'b0, 1, 1 + (i % 3));
    check("miss_count_wrap", 64'(miss_count), 64'd0);

    repeat (2) begin @(posedge clk); #1; end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
